// File: rtl/clock_disp_pkg.sv
// Shared display definitions: segment constants, the BCD segment table
// and the digit index type used by the scan driver.
package clock_disp_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;

   // Segment order a..g, a in bit 6; entry 0 is the rightmost element.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b1111011,  // 9
      7'b1111111,  // 8
      7'b1110000,  // 7
      7'b1011111,  // 6
      7'b1011011,  // 5
      7'b0110011,  // 4
      7'b1111001,  // 3
      7'b1101101,  // 2
      7'b0110000,  // 1
      7'b1111110   // 0
   };

   typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder; non-decimal codes show a dash.
module bcd_to_7seg
   import clock_disp_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      if (bcd_i <= 4'd9) seg_o = SEG_TABLE[bcd_i];
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scanner with per-frame shadow
// capture, leading-zero suppression and a blanking gap at each slot start.
module seg_scan_driver
   import clock_disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV    = 1000,
   parameter int unsigned BLANK_CYC   = 16,
   parameter bit          LZ_SUPPRESS = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] blank_mask,
   input  logic [3:0] dp,
   output logic [1:0] sel,
   output logic [6:0] seg,
   output logic       seg_dp,
   output logic [3:0] an_n,
   output logic       frame_tick
);

   localparam int unsigned CW = $clog2(SCAN_DIV);

   logic [CW-1:0]   cnt_q, cnt_d;
   digit_idx_t      sel_q, sel_d;
   logic [3:0][3:0] dig_q, dig_d;
   logic [3:0]      dp_q, dp_d;
   logic [3:0]      bm_q, bm_d;
   logic [6:0]      seg_q, seg_d;
   logic            seg_dp_q, seg_dp_d;
   logic [3:0]      an_n_q, an_n_d;
   logic            tick_q, tick_d;

   logic [3:0]      lz, blank_v;
   logic            show, lit;
   logic [6:0]      dec_seg;

   // Decoder looks at the next-state digit so every registered output
   // describes the same slot as the registered sel.
   bcd_to_7seg u_dec (
      .bcd_i (dig_d[sel_d]),
      .seg_o (dec_seg)
   );

   always_comb begin
      cnt_d  = cnt_q;
      sel_d  = sel_q;
      dig_d  = dig_q;
      dp_d   = dp_q;
      bm_d   = bm_q;
      tick_d = 1'b0;
      if (en) begin
         if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            sel_d = sel_q + 2'd1;
            if (sel_q == 2'd3) begin
               dig_d  = {d3, d2, d1, d0};
               dp_d   = dp;
               bm_d   = blank_mask;
               tick_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      lz[3] = (dig_d[3] == 4'd0);
      lz[2] = lz[3] && (dig_d[2] == 4'd0);
      lz[1] = lz[2] && (dig_d[1] == 4'd0);
      lz[0] = 1'b0;
      blank_v = bm_d | (LZ_SUPPRESS ? lz : 4'b0000);

      show     = en && !blank_v[sel_d];
      lit      = show && (cnt_d >= CW'(BLANK_CYC));
      seg_d    = show ? dec_seg : SEG_BLANK;
      an_n_d   = lit ? ~(4'b0001 << sel_d) : 4'b1111;
      seg_dp_d = lit && dp_d[sel_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         sel_q    <= '0;
         dig_q    <= '0;
         dp_q     <= '0;
         bm_q     <= 4'b1111;
         seg_q    <= SEG_BLANK;
         seg_dp_q <= 1'b0;
         an_n_q   <= 4'b1111;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         dig_q    <= dig_d;
         dp_q     <= dp_d;
         bm_q     <= bm_d;
         seg_q    <= seg_d;
         seg_dp_q <= seg_dp_d;
         an_n_q   <= an_n_d;
         tick_q   <= tick_d;
      end
   end

   assign sel        = sel_q;
   assign seg        = seg_q;
   assign seg_dp     = seg_dp_q;
   assign an_n       = an_n_q;
   assign frame_tick = tick_q;

endmodule
